// File: rtl/ecc_44_scrub_ctrl_if.sv
// Memory-side bus of the 44/7 SECDED scrubber: req/gnt handshake with address and data.
interface ecc_44_scrub_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic              mem_req;
   logic              mem_gnt;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [50:0]       mem_wdata;
   logic [50:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rdata
   );
endinterface

// File: rtl/ecc_44_scrub_ctrl.sv
// Background scrubber for a 44-bit data + 7-bit SECDED SRAM, driving an external codec.
// Optional error log ports are enabled by defining ECC_SCRUB_ERR_LOG_EN.
module ecc_44_scrub_ctrl #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scrub_en,
   input  logic [15:0]          scrub_interval,
   input  logic                 cnt_clr,
   ecc_44_scrub_ctrl_if.master  mem_bus,
   output logic [43:0]          codec_data_in,
   output logic [6:0]           codec_parity_in,
   output logic                 codec_bypass,
   input  logic [43:0]          codec_data_out,
   input  logic [6:0]           codec_parity_out,
   input  logic                 codec_sbit,
   input  logic                 codec_dbit,
   output logic [CNT_W-1:0]     sbe_cnt,
   output logic [CNT_W-1:0]     dbe_cnt,
   output logic                 err_irq,
   output logic                 pass_done
`ifdef ECC_SCRUB_ERR_LOG_EN
   ,
   output logic [ADDR_W-1:0]    last_err_addr,
   output logic [0:0]           last_err_dbit
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_RD   = 3'd2,
      ST_CHK  = 3'd3,
      ST_WB   = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_t            state_r;
   logic [15:0]       timer_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic              wrap_s;
   logic [43:0]       corr_data_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic              err_irq_r;
   logic              pass_done_r;
   logic [CNT_W-1:0]  sbe_cnt_r;
   logic [CNT_W-1:0]  dbe_cnt_r;
   logic              sbe_inc_s;
   logic              dbe_inc_s;
`ifdef ECC_SCRUB_ERR_LOG_EN
   logic [ADDR_W-1:0] last_err_addr_r;
   logic [0:0]        last_err_dbit_r;
`endif

   assign sbe_inc_s = (state_r == ST_CHK) && codec_sbit && !codec_dbit;
   assign dbe_inc_s = (state_r == ST_CHK) && codec_dbit;

   // next scrub address with wrap at the last word
   always_comb begin
      wrap_s = (addr_r == LAST_ADDR);
      if (wrap_s) begin
         addr_nxt_s = {ADDR_W{1'b0}};
      end else begin
         addr_nxt_s = addr_r + ADDR_W'(1);
      end
   end

   // codec steering: decode the read word in CHK, re-encode corrected data in WB
   always_comb begin
      codec_data_in   = 44'd0;
      codec_parity_in = 7'd0;
      codec_bypass    = 1'b1;
      case (state_r)
         ST_CHK: begin
            codec_data_in   = mem_bus.mem_rdata[43:0];
            codec_parity_in = mem_bus.mem_rdata[50:44];
            codec_bypass    = 1'b0;
         end
         ST_WB: begin
            codec_data_in   = corr_data_r;
         end
         default: begin
            codec_data_in   = 44'd0;
         end
      endcase
   end

   // write-back word uses the codec's fresh parity for the corrected data
   always_comb begin
      if (state_r == ST_WB) begin
         mem_bus.mem_wdata = {codec_parity_out, corr_data_r};
      end else begin
         mem_bus.mem_wdata = 51'd0;
      end
   end

   // scrub sequencer with registered bus and pulse outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         timer_r     <= 16'd0;
         addr_r      <= {ADDR_W{1'b0}};
         corr_data_r <= 44'd0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         err_irq_r   <= 1'b0;
         pass_done_r <= 1'b0;
`ifdef ECC_SCRUB_ERR_LOG_EN
         last_err_addr_r <= {ADDR_W{1'b0}};
         last_err_dbit_r <= 1'b0;
`endif
      end else begin
         err_irq_r   <= 1'b0;
         pass_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (scrub_en) begin
                  state_r <= ST_WAIT;
                  timer_r <= scrub_interval;
               end
            end
            ST_WAIT: begin
               if (!scrub_en) begin
                  state_r <= ST_IDLE;
               end else if (timer_r == 16'd0) begin
                  state_r   <= ST_RD;
                  mem_req_r <= 1'b1;
                  mem_we_r  <= 1'b0;
               end else begin
                  timer_r <= timer_r - 16'd1;
               end
            end
            ST_RD: begin
               // a grant in the same cycle as scrub_en dropping still completes the access
               if (mem_bus.mem_gnt) begin
                  state_r   <= ST_CHK;
                  mem_req_r <= 1'b0;
               end else if (!scrub_en) begin
                  state_r   <= ST_IDLE;
                  mem_req_r <= 1'b0;
               end
            end
            ST_CHK: begin
               corr_data_r <= codec_data_out;
               err_irq_r   <= codec_dbit;
`ifdef ECC_SCRUB_ERR_LOG_EN
               if (codec_sbit || codec_dbit) begin
                  last_err_addr_r <= addr_r;
                  last_err_dbit_r <= codec_dbit;
               end
`endif
               if (codec_sbit && !codec_dbit) begin
                  state_r   <= ST_WB;
                  mem_req_r <= 1'b1;
                  mem_we_r  <= 1'b1;
               end else begin
                  addr_r      <= addr_nxt_s;
                  pass_done_r <= wrap_s;
                  timer_r     <= scrub_interval;
                  state_r     <= scrub_en ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WB: begin
               if (mem_bus.mem_gnt) begin
                  mem_req_r   <= 1'b0;
                  mem_we_r    <= 1'b0;
                  addr_r      <= addr_nxt_s;
                  pass_done_r <= wrap_s;
                  timer_r     <= scrub_interval;
                  state_r     <= scrub_en ? ST_WAIT : ST_IDLE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               mem_req_r <= 1'b0;
               mem_we_r  <= 1'b0;
            end
         endcase
      end
   end

   // saturating error counters; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sbe_cnt_r <= {CNT_W{1'b0}};
         dbe_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         sbe_cnt_r <= {CNT_W{1'b0}};
         dbe_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (sbe_inc_s && (sbe_cnt_r != CNT_MAX)) begin
            sbe_cnt_r <= sbe_cnt_r + CNT_W'(1);
         end
         if (dbe_inc_s && (dbe_cnt_r != CNT_MAX)) begin
            dbe_cnt_r <= dbe_cnt_r + CNT_W'(1);
         end
      end
   end

   assign mem_bus.mem_req  = mem_req_r;
   assign mem_bus.mem_we   = mem_we_r;
   assign mem_bus.mem_addr = addr_r;
   assign sbe_cnt          = sbe_cnt_r;
   assign dbe_cnt          = dbe_cnt_r;
   assign err_irq          = err_irq_r;
   assign pass_done        = pass_done_r;
`ifdef ECC_SCRUB_ERR_LOG_EN
   assign last_err_addr    = last_err_addr_r;
   assign last_err_dbit    = last_err_dbit_r;
`endif

endmodule

// File: tb/tb_ecc_44_scrub_ctrl.sv
// Bench for ecc_44_scrub_ctrl: SRAM and SECDED codec models plus an access scoreboard.
module tb_ecc_44_scrub_ctrl;
   localparam int DEPTH    = 8;
   localparam int ADDR_W   = 3;
   localparam int CNT_W    = 2;
   localparam int INTERVAL = 4;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [50:0]       wdata;
   } acc_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              scrub_en;
   logic [15:0]       scrub_interval;
   logic              cnt_clr;
   logic [43:0]       codec_data_in;
   logic [6:0]        codec_parity_in;
   logic              codec_bypass;
   logic [43:0]       codec_data_out;
   logic [6:0]        codec_parity_out;
   logic              codec_sbit;
   logic              codec_dbit;
   logic [CNT_W-1:0]  sbe_cnt;
   logic [CNT_W-1:0]  dbe_cnt;
   logic              err_irq;
   logic              pass_done;
`ifdef ECC_SCRUB_ERR_LOG_EN
   logic [ADDR_W-1:0] last_err_addr;
   logic [0:0]        last_err_dbit;
`endif

   ecc_44_scrub_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

   ecc_44_scrub_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .scrub_en         (scrub_en),
      .scrub_interval   (scrub_interval),
      .cnt_clr          (cnt_clr),
      .mem_bus          (mem_bus),
      .codec_data_in    (codec_data_in),
      .codec_parity_in  (codec_parity_in),
      .codec_bypass     (codec_bypass),
      .codec_data_out   (codec_data_out),
      .codec_parity_out (codec_parity_out),
      .codec_sbit       (codec_sbit),
      .codec_dbit       (codec_dbit),
      .sbe_cnt          (sbe_cnt),
      .dbe_cnt          (dbe_cnt),
      .err_irq          (err_irq),
      .pass_done        (pass_done)
`ifdef ECC_SCRUB_ERR_LOG_EN
      ,
      .last_err_addr    (last_err_addr),
      .last_err_dbit    (last_err_dbit)
`endif
   );

   always #5 clk = ~clk;

   // Hamming positions 1..50, data in non-power-of-two slots, p[6] is overall parity
   function automatic logic [6:0] ecc_enc(input logic [43:0] d);
      logic [5:0] h;
      int k;
      h = 6'd0;
      k = 0;
      for (int pos = 1; pos <= 50; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[k]) h = h ^ 6'(pos);
            k++;
         end
      end
      return {(^d) ^ (^h), h};
   endfunction

   // returns {sbit, dbit, corrected data}
   function automatic logic [45:0] ecc_dec(input logic [43:0] d, input logic [6:0] p);
      logic [6:0]  pe;
      logic [5:0]  s;
      logic        ov;
      logic [43:0] c;
      int k;
      pe = ecc_enc(d);
      s  = pe[5:0] ^ p[5:0];
      ov = (^d) ^ (^p);
      c  = d;
      k  = 0;
      if (ov) begin
         for (int pos = 1; pos <= 50; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
               if (6'(pos) == s) c[k] = ~c[k];
               k++;
            end
         end
         return {1'b1, 1'b0, c};
      end else if (s != 6'd0) begin
         return {1'b0, 1'b1, d};
      end
      return {2'b00, d};
   endfunction

   logic [45:0] dec_s;
   always_comb begin
      dec_s            = ecc_dec(codec_data_in, codec_parity_in);
      codec_parity_out = ecc_enc(codec_data_in);
      if (codec_bypass) begin
         codec_data_out = codec_data_in;
         codec_sbit     = 1'b0;
         codec_dbit     = 1'b0;
      end else begin
         codec_data_out = dec_s[43:0];
         codec_sbit     = dec_s[45];
         codec_dbit     = dec_s[44];
      end
   end

   // SRAM model with bench-side load and bit-flip injection
   logic [50:0] mem_q [DEPTH];
   logic [43:0] orig_q [DEPTH];
   logic        load_req = 1'b0;
   logic        inj_req = 1'b0;
   int          inj_addr = 0;
   logic [50:0] inj_mask = 51'd0;

   initial begin
      mem_bus.mem_rdata <= 51'd0;
      forever begin
         @(posedge clk);
         if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] = {ecc_enc(orig_q[i]), orig_q[i]};
         end
         if (inj_req) mem_q[inj_addr] = mem_q[inj_addr] ^ inj_mask;
         if (mem_bus.mem_req && mem_bus.mem_gnt) begin
            if (mem_bus.mem_we) mem_q[mem_bus.mem_addr] = mem_bus.mem_wdata;
            else mem_bus.mem_rdata <= mem_q[mem_bus.mem_addr];
         end
      end
   end

   int   total = 0;
   int   bad = 0;
   acc_t exp_q[$];
   int   rd_cyc_q[$];
   int   cyc = 0;
   int   acc_cnt = 0;
   int   wr_cnt = 0;
   int   pd_cnt = 0;
   int   irq_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // monitor: every granted access is popped against the scoreboard
   initial begin
      acc_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (pass_done) pd_cnt++;
         if (err_irq) irq_cyc++;
         if (rst_n && mem_bus.mem_req && mem_bus.mem_gnt) begin
            acc_cnt++;
            if (mem_bus.mem_we) wr_cnt++;
            else rd_cyc_q.push_back(cyc);
            check("acc_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("acc_we", 64'(mem_bus.mem_we), 64'(e.we));
               check("acc_addr", 64'(mem_bus.mem_addr), 64'(e.addr));
               if (e.we) check("acc_wdata", 64'(mem_bus.mem_wdata), 64'(e.wdata));
            end
         end
      end
   end

   task automatic push_rd(input int a);
      acc_t e;
      e.we = 1'b0; e.addr = ADDR_W'(a); e.wdata = 51'd0;
      exp_q.push_back(e);
   endtask

   task automatic push_wr(input int a);
      acc_t e;
      e.we = 1'b1; e.addr = ADDR_W'(a); e.wdata = {ecc_enc(orig_q[a]), orig_q[a]};
      exp_q.push_back(e);
   endtask

   task automatic inject(input int a, input logic [50:0] m);
      @(posedge clk); #1;
      inj_addr = a; inj_mask = m; inj_req = 1'b1;
      @(posedge clk); #1;
      inj_req = 1'b0;
   endtask

   task automatic reload();
      @(posedge clk); #1;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic start();
      @(posedge clk); #1;
      scrub_en = 1'b1;
   endtask

   // returns right after the posedge on which access number n was granted
   task automatic wait_acc(input int n);
      int b;
      b = 0;
      while (acc_cnt < n && b < 3000) begin
         @(posedge clk);
         b++;
      end
      check("acc_count_reached", 64'(acc_cnt), 64'(n));
   endtask

   task automatic stop();
      #1 scrub_en = 1'b0;
      repeat (4) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] r;
      int a0, pd0, wr0, irq0;
      rst_n = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
      scrub_interval = 16'(INTERVAL);
      mem_bus.mem_gnt = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         r = {$urandom, $urandom};
         orig_q[i] = r[43:0];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_bus", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}, 64'd0);
      check("rst_cnt", {sbe_cnt, dbe_cnt}, 64'd0);
      check("rst_pulses", {err_irq, pass_done}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      reload();

      // clean pass: one read every (INTERVAL+1) wait + RD + CHK cycles
      mem_bus.mem_gnt = 1'b1;
      for (int i = 0; i < DEPTH; i++) push_rd(i);
      pd0 = pd_cnt; wr0 = wr_cnt; rd_cyc_q.delete();
      a0 = acc_cnt;
      start();
      wait_acc(a0 + DEPTH);
      stop();
      for (int i = 1; i < rd_cyc_q.size(); i++)
         check("t1_read_period", 64'(rd_cyc_q[i] - rd_cyc_q[i-1]), 64'(INTERVAL + 3));
      check("t1_writes", 64'(wr_cnt - wr0), 64'd0);
      check("t1_pass_done", 64'(pd_cnt - pd0), 64'd1);
      check("t1_addr_wrapped", 64'(mem_bus.mem_addr), 64'd0);
      check("t1_counts", {sbe_cnt, dbe_cnt}, 64'd0);

      // single data-bit error at 3 is repaired, then reread clean
      inject(3, 51'd1 << 5);
      for (int i = 0; i < DEPTH; i++) begin
         push_rd(i);
         if (i == 3) push_wr(3);
      end
      for (int i = 0; i < 4; i++) push_rd(i);
      a0 = acc_cnt;
      start();
      wait_acc(a0 + 13);
      stop();
      check("t2_sbe", 64'(sbe_cnt), 64'd1);
      check("t2_dbe", 64'(dbe_cnt), 64'd0);
      check("t2_mem_fixed", 64'(mem_q[3]), 64'({ecc_enc(orig_q[3]), orig_q[3]}));

      // double-bit error at 6: counted and flagged, never written
      inject(6, (51'd1 << 0) | (51'd1 << 9));
      for (int i = 4; i < DEPTH; i++) push_rd(i);
      irq0 = irq_cyc; pd0 = pd_cnt;
      a0 = acc_cnt;
      start();
      wait_acc(a0 + 4);
      stop();
      check("t3_dbe", 64'(dbe_cnt), 64'd1);
      check("t3_sbe", 64'(sbe_cnt), 64'd1);
      check("t3_irq_cycles", 64'(irq_cyc - irq0), 64'd1);
      check("t3_pass_done", 64'(pd_cnt - pd0), 64'd1);
`ifdef ECC_SCRUB_ERR_LOG_EN
      check("t3_last_addr", 64'(last_err_addr), 64'd6);
      check("t3_last_dbit", 64'(last_err_dbit), 64'd1);
`endif
      reload();

      // grant withheld: request and address hold, access on first grant cycle
      mem_bus.mem_gnt = 1'b0;
      push_rd(0);
      start();
      for (int b = 0; b < 50 && !mem_bus.mem_req; b++) @(negedge clk);
      check("t4_req_seen", 64'(mem_bus.mem_req), 64'd1);
      repeat (10) begin
         @(negedge clk);
         check("t4_hold", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}, {1'b1, 1'b0, 3'd0});
      end
      @(posedge clk); #1 mem_bus.mem_gnt = 1'b1;
      a0 = acc_cnt;
      @(posedge clk);
      check("t4_first_gnt", 64'(acc_cnt), 64'(a0 + 1));
      stop();

      // reset while stuck in write-back: write dropped, restart from 0
      inject(1, 51'd1 << 20);
      push_rd(1);
      a0 = acc_cnt;
      start();
      wait_acc(a0 + 1);
      #1 mem_bus.mem_gnt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5_in_wb", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}, {1'b1, 1'b1, 3'd1});
      @(posedge clk); #1 rst_n = 1'b0; scrub_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("t5_bus_zero", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr}, 64'd0);
      check("t5_cnt_zero", {sbe_cnt, dbe_cnt, err_irq, pass_done}, 64'd0);
      @(posedge clk); #1 mem_bus.mem_gnt = 1'b1;
      push_rd(0);
      a0 = acc_cnt;
      start();
      wait_acc(a0 + 1);
      stop();
      check("t5_no_writeback", 64'(mem_q[1]), 64'({ecc_enc(orig_q[1]), orig_q[1]} ^ (51'd1 << 20)));
      reload();

      // five correctable errors saturate the 2-bit counter
      for (int i = 1; i <= 5; i++) begin
         inject(i, 51'd1 << (i * 7));
         push_rd(i);
         push_wr(i);
      end
      a0 = acc_cnt;
      start();
      wait_acc(a0 + 10);
      stop();
      check("t6_sbe_sat", 64'(sbe_cnt), 64'd3);
      @(posedge clk); #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      check("t6_clr", 64'(sbe_cnt), 64'd0);

      // clear coincident with an increment wins; parity-only error still repaired
      inject(6, 51'd1 << 40);
      inject(7, 51'd1 << 46);
      push_rd(6); push_wr(6); push_rd(7); push_wr(7);
      a0 = acc_cnt;
      start();
      wait_acc(a0 + 1);
      #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      check("t6_clr_wins", 64'(sbe_cnt), 64'd0);
      wait_acc(a0 + 4);
      stop();
      check("t6_sbe_after", 64'(sbe_cnt), 64'd1);
      check("t6_dbe", 64'(dbe_cnt), 64'd0);
      check("t6_mem7", 64'(mem_q[7]), 64'({ecc_enc(orig_q[7]), orig_q[7]}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
